// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM encoding and
// default timing parameters.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } arb_state_e;

    localparam int TIMEOUT_DEF    = 15;
    localparam int I_MAX_WAIT_DEF = 4;

endpackage

// File: rtl/arb_wdog.sv
// Grant watchdog: counts granted cycles without m_ready and flags expiry on the
// cycle the count reaches TIMEOUT-1 with the access still outstanding.
module arb_wdog
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int              CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] wait_cnt;

    // NOTE: state uses non-blocking assignments under an async reset so every
    // flop samples pre-edge values and clears the instant rst drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (clr) begin
            wait_cnt <= '0;
        end else if (en) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign expire = en && (wait_cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: fetch and load/store share one memory bus, data wins
// ties unless the fetch port has been starved I_MAX_WAIT times in a row.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT    = TIMEOUT_DEF,
    parameter int I_MAX_WAIT = I_MAX_WAIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_data,
    output logic        i_stall,
    input  logic        d_ren,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_stall,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ready,
    output logic        bus_err
);

    localparam int            SW         = $clog2(I_MAX_WAIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(I_MAX_WAIT);

    arb_state_e    state, state_nxt;
    logic          i_done, d_done;
    logic [SW-1:0] starve_cnt;
    logic          d_any, i_pend, d_pend, force_i;
    logic          grant_i, grant_d, wd_en, expire, finish;

    assign d_any   = d_ren | d_wen;
    assign i_pend  = i_req & ~i_done;
    assign d_pend  = d_any & ~d_done;
    assign force_i = i_pend && (starve_cnt == STARVE_MAX);

    assign i_stall = i_pend;
    assign d_stall = d_pend;
    assign m_req   = (state != ST_IDLE);
    assign wd_en   = m_req & ~m_ready;
    assign finish  = m_req & (m_ready | expire);

    arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (grant_i | grant_d),
        .en     (wd_en),
        .expire (expire)
    );

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (d_pend && !force_i) begin
                    grant_d   = 1'b1;
                    state_nxt = ST_GNT_D;
                end else if (i_pend) begin
                    grant_i   = 1'b1;
                    state_nxt = ST_GNT_I;
                end
            end
            ST_GNT_I, ST_GNT_D: begin
                if (finish) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            i_data     <= '0;
            d_rdata    <= '0;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
            starve_cnt <= '0;
            bus_err    <= 1'b0;
        end else begin
            state   <= state_nxt;
            i_done  <= 1'b0;
            d_done  <= 1'b0;
            bus_err <= finish & ~m_ready;

            if (grant_d) begin
                m_addr  <= d_addr;
                m_we    <= d_wen;
                m_wdata <= d_wdata;
                if (i_pend && starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
            end
            if (grant_i) begin
                m_addr     <= i_addr;
                m_we       <= 1'b0;
                m_wdata    <= '0;
                starve_cnt <= '0;
            end

            // A requester that let go mid-access gets neither data nor a done pulse.
            if (finish) begin
                m_we <= 1'b0;
                if (state == ST_GNT_I && i_req) begin
                    i_done <= 1'b1;
                    i_data <= m_ready ? m_rdata : '0;
                end
                if (state == ST_GNT_D && d_any) begin
                    d_done <= 1'b1;
                    d_rdata <= m_ready ? m_rdata : '0;
                end
            end
        end
    end

endmodule
